// File: rtl/call_latch.sv
// Elevator hall/car call latch: synchronizes, debounces and latches
// pushbutton calls until the controller services them.
module call_latch #(
    parameter int CLK_PER_SAMPLE = 1000000,
    parameter int SAMPLES        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] rawFloorButton,
    input  logic [9:1]  rawInternalButton,
    input  logic [13:0] clearFloorButton,
    input  logic [7:1]  clearInternalButton,
    output logic [13:0] floorButton,
    output logic [9:1]  internalButton,
    output logic        anyCall
);

    localparam int N  = 23;
    localparam int CW = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;
    // Floor 1 has no DOWN call and floor 7 has no UP call.
    localparam logic [13:0] HALL_MASK = 14'h1FFE;

    logic [N-1:0]       raw;
    logic [N-1:0]       meta_q;
    logic [N-1:0]       sync_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               tick;
    logic [SAMPLES-1:0] hist_q [N];
    logic [SAMPLES-1:0] hist_d [N];
    logic [N-1:0]       deb_q;
    logic [N-1:0]       deb_d;
    logic [N-1:0]       deb_prev_q;
    logic [N-1:0]       rise;
    logic [13:0]        hall_q;
    logic [13:0]        hall_d;
    logic [7:1]         car_q;
    logic [7:1]         car_d;

    assign raw  = {rawInternalButton, rawFloorButton};
    assign tick = (cnt_q == CW'(CLK_PER_SAMPLE - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            hist_d[i] = hist_q[i];
            deb_d[i]  = deb_q[i];
            if (tick) begin
                hist_d[i] = {hist_q[i][SAMPLES-2:0], sync_q[i]};
                if (&hist_d[i]) begin
                    deb_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    deb_d[i] = 1'b0;
                end
            end
        end
    end

    // Set wins over a coincident clear.
    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        hall_d = ((hall_q & ~clearFloorButton) | rise[13:0]) & HALL_MASK;
        car_d  = (car_q & ~clearInternalButton) | rise[20:14];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            cnt_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            hall_q     <= '0;
            car_q      <= '0;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            hall_q     <= hall_d;
            car_q      <= car_d;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign floorButton       = hall_q;
    assign internalButton[7:1] = car_q;
    assign internalButton[8] = deb_q[21];
    assign internalButton[9] = deb_q[22] & ~deb_q[21];
    assign anyCall           = (|hall_q) | (|car_q);

endmodule

// File: tb/tb_call_latch.sv
// Scoreboard bench for call_latch with CLK_PER_SAMPLE=4, SAMPLES=3.
module tb_call_latch;

    logic        clk;
    logic        reset;
    logic [13:0] rawFloorButton;
    logic [9:1]  rawInternalButton;
    logic [13:0] clearFloorButton;
    logic [7:1]  clearInternalButton;
    logic [13:0] floorButton;
    logic [9:1]  internalButton;
    logic        anyCall;

    typedef struct {
        logic [13:0] f;
        logic [9:1]  i;
        logic        a;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;
    bit   ok;

    call_latch #(.CLK_PER_SAMPLE(4), .SAMPLES(3)) dut (
        .clk                 (clk),
        .reset               (reset),
        .rawFloorButton      (rawFloorButton),
        .rawInternalButton   (rawInternalButton),
        .clearFloorButton    (clearFloorButton),
        .clearInternalButton (clearInternalButton),
        .floorButton         (floorButton),
        .internalButton      (internalButton),
        .anyCall             (anyCall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [13:0] f, input logic [9:1] i,
                            input logic a);
        exp_t e;
        e.f = f;
        e.i = i;
        e.a = a;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, ".fb"}, 32'(floorButton), 32'(e.f));
            check({tag, ".ib"}, 32'(internalButton), 32'(e.i));
            check({tag, ".any"}, 32'(anyCall), 32'(e.a));
        end
    endtask

    task automatic wait_floor(input logic [13:0] mask, input int budget,
                              output int n_lat, output bit found);
        found = 1'b0;
        n_lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((floorButton & mask) == mask) begin
                found = 1'b1;
                n_lat = n;
                break;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_floor_clr(input logic [13:0] m);
        @(negedge clk);
        clearFloorButton = m;
        @(negedge clk);
        clearFloorButton = '0;
    endtask

    task automatic pulse_car_clr(input logic [7:1] m);
        @(negedge clk);
        clearInternalButton = m;
        @(negedge clk);
        clearInternalButton = '0;
    endtask

    initial begin
        reset               = 1'b0;
        rawFloorButton      = '0;
        rawInternalButton   = '0;
        clearFloorButton    = '0;
        clearInternalButton = '0;
        cycles(3);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("reset");
        reset = 1'b1;
        cycles(5);

        rawFloorButton[3] = 1'b1;
        wait_floor(14'h0008, 30, lat, ok);
        check("press.found", 32'(ok), 1);
        check("press.lat", 32'(lat >= 12 && lat <= 15), 1);
        push_exp(14'h0008, 9'h0, 1'b1);
        pop_cmp("press");
        cycles(40);
        rawFloorButton[3] = 1'b0;
        cycles(20);
        push_exp(14'h0008, 9'h0, 1'b1);
        pop_cmp("released");

        rawFloorButton[3] = 1'b1;
        cycles(20);
        pulse_floor_clr(14'h0008);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("clear");
        cycles(30);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("noRelatch");
        rawFloorButton[3] = 1'b0;
        cycles(20);
        rawFloorButton[3] = 1'b1;
        wait_floor(14'h0008, 30, lat, ok);
        check("relatch.found", 32'(ok), 1);
        push_exp(14'h0008, 9'h0, 1'b1);
        pop_cmp("relatch");
        rawFloorButton[3] = 1'b0;
        cycles(20);
        pulse_floor_clr(14'h0008);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("clear2");

        for (int k = 0; k < 10; k++) begin
            rawInternalButton[4] = ~k[0];
            cycles(3);
        end
        rawInternalButton[4] = 1'b0;
        cycles(20);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("bounce");

        clearInternalButton[2] = 1'b1;
        rawInternalButton[2]   = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (internalButton[2]) begin
                ok = 1'b1;
                break;
            end
        end
        clearInternalButton[2] = 1'b0;
        check("setWins", 32'(ok), 1);
        @(negedge clk);
        push_exp(14'h0, 9'h002, 1'b1);
        pop_cmp("setHeld");
        rawInternalButton[2] = 1'b0;
        cycles(20);
        pulse_car_clr(7'h02);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("carClear");

        rawFloorButton[0]    = 1'b1;
        rawFloorButton[13]   = 1'b1;
        rawInternalButton[8] = 1'b1;
        rawInternalButton[9] = 1'b1;
        cycles(25);
        pulse_floor_clr(14'h2001);
        push_exp(14'h0, 9'h080, 1'b0);
        pop_cmp("doors");
        rawInternalButton[8] = 1'b0;
        cycles(25);
        push_exp(14'h0, 9'h100, 1'b0);
        pop_cmp("closeOnly");
        rawFloorButton    = '0;
        rawInternalButton = '0;
        cycles(25);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("idle");

        rawFloorButton = 14'h0AAA;
        wait_floor(14'h0AAA, 30, lat, ok);
        check("aaa.found", 32'(ok), 1);
        rawFloorButton = '0;
        cycles(20);
        push_exp(14'h0AAA, 9'h0, 1'b1);
        pop_cmp("aaa");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("rstNow");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("rstAfter");
        cycles(25);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("rstQuiet");

        reset = 1'b0;
        rawFloorButton[5] = 1'b1;
        cycles(3);
        reset = 1'b1;
        wait_floor(14'h0020, 30, lat, ok);
        check("heldRst.found", 32'(ok), 1);
        pulse_floor_clr(14'h0020);
        cycles(30);
        push_exp(14'h0, 9'h0, 1'b0);
        pop_cmp("once");
        rawFloorButton = '0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
